// File: rtl/pwm_pkg.sv
// Shared constants and the period-counter stepping rule for the multi-channel PWM.
// The step function works on a fixed 32-bit carrier; callers truncate to their width.
package pwm_pkg;

    localparam int PWM_MAX_WIDTH = 32;

    localparam logic PWM_MODE_EDGE   = 1'b0;
    localparam logic PWM_MODE_CENTER = 1'b1;

    localparam logic [PWM_MAX_WIDTH-1:0] PWM_RESET_PERIOD = '1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    typedef struct packed {
        logic [PWM_MAX_WIDTH-1:0] cnt;
        pwm_dir_e                 dir;
    } pwm_step_t;

    // Next count/direction; a result of cnt=0 always comes with dir=up.
    function automatic pwm_step_t pwm_next_count(
        input logic [PWM_MAX_WIDTH-1:0] cnt,
        input pwm_dir_e                 dir,
        input logic [PWM_MAX_WIDTH-1:0] period,
        input logic                     center
    );
        pwm_step_t s;
        s.cnt = '0;
        s.dir = DIR_UP;
        if (center == PWM_MODE_EDGE) begin
            if (cnt < period) s.cnt = cnt + 1;
        end else if (dir == DIR_UP) begin
            if (cnt < period) begin
                s.cnt = cnt + 1;
            end else if (period != '0) begin
                s.cnt = period - 1;
                s.dir = (period > 1) ? DIR_DOWN : DIR_UP;
            end
        end else if (cnt > 1) begin
            s.cnt = cnt - 1;
            s.dir = DIR_DOWN;
        end
        return s;
    endfunction

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: double-buffered duty register and the registered compare output.
module pwm_channel_cmp
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             transfer_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] duty_i,
    output logic             out_o
);

    logic [WIDTH-1:0] duty_act_q, duty_act_d;
    logic [WIDTH-1:0] duty_stg_q, duty_stg_d;
    logic             out_q, out_d;

    // Transfer reads the old staging value, so a same-edge load lands in staging only.
    always_comb begin
        duty_stg_d = load_i ? duty_i : duty_stg_q;
        duty_act_d = transfer_i ? duty_stg_q : duty_act_q;
        out_d      = enable_i && (cnt_i < duty_act_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            duty_act_q <= '0;
            duty_stg_q <= '0;
            out_q      <= 1'b0;
        end else begin
            duty_act_q <= duty_act_d;
            duty_stg_q <= duty_stg_d;
            out_q      <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: one shared edge/center-aligned period counter feeding CHANNELS
// comparators, with period/mode/duty updates applied only at a period boundary.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      load,
    input  logic [WIDTH-1:0]          period_in,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      center_in,
    output logic [CHANNELS-1:0]       out,
    output logic                      period_start,
    output logic                      pending
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    pwm_dir_e         dir_q, dir_d;
    logic [WIDTH-1:0] period_act_q, period_act_d;
    logic [WIDTH-1:0] period_stg_q, period_stg_d;
    logic             center_act_q, center_act_d;
    logic             center_stg_q, center_stg_d;
    logic             pending_q, pending_d;
    logic             period_start_q, period_start_d;
    logic             transfer;
    pwm_step_t        step;

    // Disabling is treated as a boundary: the counter parks at 0 and staged values move in.
    always_comb begin
        step           = pwm_next_count(32'(cnt_q), dir_q, 32'(period_act_q), center_act_q);
        transfer       = pending_q && (!enable || (step.cnt[WIDTH-1:0] == '0));
        cnt_d          = enable ? step.cnt[WIDTH-1:0] : '0;
        dir_d          = enable ? step.dir : DIR_UP;
        period_act_d   = transfer ? period_stg_q : period_act_q;
        center_act_d   = transfer ? center_stg_q : center_act_q;
        period_stg_d   = load ? period_in : period_stg_q;
        center_stg_d   = load ? center_in : center_stg_q;
        pending_d      = load || (pending_q && !transfer);
        period_start_d = enable && (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            dir_q          <= DIR_UP;
            period_act_q   <= PWM_RESET_PERIOD[WIDTH-1:0];
            period_stg_q   <= PWM_RESET_PERIOD[WIDTH-1:0];
            center_act_q   <= PWM_MODE_EDGE;
            center_stg_q   <= PWM_MODE_EDGE;
            pending_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            period_act_q   <= period_act_d;
            period_stg_q   <= period_stg_d;
            center_act_q   <= center_act_d;
            center_stg_q   <= center_stg_d;
            pending_q      <= pending_d;
            period_start_q <= period_start_d;
        end
    end

    if (WIDTH < PWM_MAX_WIDTH) begin : g_step_hi
        logic unused_step_hi;
        assign unused_step_hi = ^step.cnt[PWM_MAX_WIDTH-1:WIDTH];
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel_cmp #(
            .WIDTH(WIDTH)
        ) u_cmp (
            .clk_i     (clk),
            .rst_i     (rst),
            .enable_i  (enable),
            .cnt_i     (cnt_q),
            .transfer_i(transfer),
            .load_i    (load),
            .duty_i    (duty_in[i*WIDTH +: WIDTH]),
            .out_o     (out[i])
        );
    end

    assign period_start = period_start_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: configuration table, hand-written boundary sequences,
// then randomized traffic against a period-sequence reference model.
module tb_pwm_multichannel;

    localparam int W  = 8;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic            load = 1'b0;
    logic [W-1:0]    period_in = '0;
    logic [CH*W-1:0] duty_in = '0;
    logic            center_in = 1'b0;
    logic [CH-1:0]   out;
    logic            period_start;
    logic            pending;

    pwm_multichannel #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .load        (load),
        .period_in   (period_in),
        .duty_in     (duty_in),
        .center_in   (center_in),
        .out         (out),
        .period_start(period_start),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hc[CH];
    int ps_extra;

    // Reference model: the whole period is an explicit list of counter values.
    int          m_seq[$];
    int          m_pos, m_p, m_c, s_p, s_c, m_cur;
    int          m_d[CH], s_d[CH];
    bit          m_pend;
    logic [CH-1:0] m_out;
    logic        m_ps;
    bit          model_chk = 0;

    function automatic void build_seq();
        m_seq.delete();
        for (int v = 0; v <= m_p; v++) m_seq.push_back(v);
        if (m_c != 0)
            for (int v = m_p - 1; v >= 1; v--) m_seq.push_back(v);
    endfunction

    initial begin
        m_p = 255; m_c = 0; m_pos = 0;
        build_seq();
    end

    always @(posedge clk) begin
        if (rst) begin
            m_p = 255; m_c = 0; s_p = 255; s_c = 0;
            for (int i = 0; i < CH; i++) begin m_d[i] = 0; s_d[i] = 0; end
            m_pend = 0; m_out = '0; m_ps = 0; m_pos = 0;
            build_seq();
        end else begin
            m_cur = m_seq[m_pos];
            for (int i = 0; i < CH; i++) m_out[i] = enable && (m_cur < m_d[i]);
            m_ps = enable && (m_cur == 0);
            m_pos = enable ? (m_pos + 1) % m_seq.size() : 0;
            if (m_pos == 0 && m_pend) begin
                m_p = s_p; m_c = s_c;
                for (int i = 0; i < CH; i++) m_d[i] = s_d[i];
                m_pend = 0;
                build_seq();
            end
            if (load) begin
                s_p = int'(period_in); s_c = int'(center_in);
                for (int i = 0; i < CH; i++) s_d[i] = int'(duty_in[i*W +: W]);
                m_pend = 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; enable = 0; load = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic load_cfg(input logic [W-1:0] p, input logic c, input logic [CH-1:0][W-1:0] d);
        period_in = p; center_in = c; duty_in = d; load = 1;
        tick();
        load = 0;
    endtask

    task automatic wait_ps(input string nm);
        int n;
        n = 0;
        while (period_start !== 1'b1 && n < 1000) begin tick(); n++; end
        chk(nm, period_start, 1);
    endtask

    // Counts high samples per channel over one period starting at a period_start sample.
    task automatic measure(input int per);
        for (int i = 0; i < CH; i++) hc[i] = 0;
        ps_extra = 0;
        for (int c = 0; c < per; c++) begin
            for (int i = 0; i < CH; i++) hc[i] += int'(out[i]);
            if (c != 0 && period_start) ps_extra++;
            tick();
        end
    endtask

    typedef struct packed {
        logic [W-1:0]         p;
        logic                 center;
        logic [CH-1:0][W-1:0] duty;
        logic [CH-1:0][8:0]   highs;
        int                   per;
    } vec_t;

    function automatic vec_t mk(input int p, input int c, input int d0, input int d1,
                                input int d2, input int d3, input int h0, input int h1,
                                input int h2, input int h3, input int per);
        vec_t v;
        v.p = W'(p); v.center = c[0];
        v.duty[0] = W'(d0); v.duty[1] = W'(d1); v.duty[2] = W'(d2); v.duty[3] = W'(d3);
        v.highs[0] = 9'(h0); v.highs[1] = 9'(h1); v.highs[2] = 9'(h2); v.highs[3] = 9'(h3);
        v.per = per;
        return v;
    endfunction

    vec_t vecs[7];
    logic [CH-1:0][W-1:0] dv;
    int pv, tmp;

    initial begin
        vecs[0] = mk(9,   0, 0, 3, 9, 200,     0, 3, 9, 10,     10);
        vecs[1] = mk(8,   1, 4, 0, 8, 9,       7, 0, 15, 16,    16);
        vecs[2] = mk(0,   0, 1, 0, 200, 0,     1, 0, 1, 0,      1);
        vecs[3] = mk(1,   1, 1, 2, 0, 255,     1, 2, 0, 2,      2);
        vecs[4] = mk(255, 0, 128, 255, 0, 1,   128, 255, 0, 1,  256);
        vecs[5] = mk(5,   1, 1, 5, 6, 3,       1, 9, 10, 5,     10);
        vecs[6] = mk(0,   1, 1, 0, 0, 3,       1, 0, 0, 1,      1);

        do_reset();
        chk("rst_out", out, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_pending", pending, 0);

        foreach (vecs[k]) begin
            do_reset();
            load_cfg(vecs[k].p, vecs[k].center, vecs[k].duty);
            chk($sformatf("v%0d_pend_set", k), pending, 1);
            tick();
            chk($sformatf("v%0d_pend_clr", k), pending, 0);
            enable = 1;
            wait_ps($sformatf("v%0d_first_ps", k));
            measure(vecs[k].per);
            for (int i = 0; i < CH; i++)
                chk($sformatf("v%0d_high_ch%0d", k, i), hc[i], 32'(vecs[k].highs[i]));
            chk($sformatf("v%0d_ps_extra", k), ps_extra, 0);
            chk($sformatf("v%0d_ps_next", k), period_start, 1);
        end

        // Mid-period duty change 5 -> 2
        do_reset();
        dv = '0; dv[0] = 8'd5;
        load_cfg(8'd9, 1'b0, dv); tick(); enable = 1;
        wait_ps("mid_ps0");
        tmp = 0;
        for (int c = 0; c < 10; c++) begin
            tmp += int'(out[0]);
            load = (c == 3);
            if (c == 3) duty_in[7:0] = 8'd2;
            if (c == 4) chk("mid_pend_early", pending, 1);
            if (c == 8) chk("mid_pend_late", pending, 1);
            if (c == 9) chk("mid_pend_clr", pending, 0);
            tick();
        end
        load = 0;
        chk("mid_old_high", tmp, 5);
        chk("mid_ps1", period_start, 1);
        measure(10);
        chk("mid_new_high", hc[0], 2);

        // Load on the boundary edge with A already staged
        do_reset();
        dv = '0; dv[0] = 8'd5;
        load_cfg(8'd9, 1'b0, dv); tick(); enable = 1;
        wait_ps("sim_ps0");
        for (int c = 0; c < 10; c++) begin
            load = (c == 2) || (c == 8);
            if (c == 2) duty_in[7:0] = 8'd7;
            if (c == 8) duty_in[7:0] = 8'd1;
            if (c == 9) chk("sim_pend_kept", pending, 1);
            tick();
        end
        load = 0;
        chk("sim_ps1", period_start, 1);
        measure(10);
        chk("sim_a_high", hc[0], 7);
        chk("sim_pend_clr", pending, 0);
        measure(10);
        chk("sim_b_high", hc[0], 1);

        // Drop enable mid-period, then re-enable with a new staged period
        do_reset();
        dv = '0; dv[0] = 8'd5;
        load_cfg(8'd9, 1'b0, dv); tick(); enable = 1;
        wait_ps("dis_ps0");
        for (int c = 0; c < 4; c++) begin
            load = (c == 1);
            if (c == 1) begin period_in = 8'd4; duty_in[7:0] = 8'd2; end
            if (c == 3) enable = 0;
            tick();
        end
        load = 0;
        chk("dis_out", out, 0);
        chk("dis_ps", period_start, 0);
        chk("dis_pend", pending, 0);
        tick(); tick();
        chk("dis_out_hold", out, 0);
        enable = 1;
        tick();
        chk("reen_ps", period_start, 1);
        measure(5);
        chk("reen_high", hc[0], 2);
        chk("reen_ps_extra", ps_extra, 0);
        chk("reen_ps_next", period_start, 1);

        // Reset mid-period discards staging and restores the 256-cycle period
        do_reset();
        dv = '0; dv[0] = 8'd5;
        load_cfg(8'd9, 1'b0, dv); tick(); enable = 1;
        wait_ps("rmid_ps0");
        tick(); tick();
        period_in = 8'd3; load = 1; tick(); load = 0;
        rst = 1; tick();
        chk("rmid_out", out, 0);
        chk("rmid_ps", period_start, 0);
        chk("rmid_pend", pending, 0);
        rst = 0;
        wait_ps("rmid_ps1");
        measure(256);
        chk("rmid_high", hc[0], 0);
        chk("rmid_ps_extra", ps_extra, 0);
        chk("rmid_ps_next", period_start, 1);

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            enable = ($urandom_range(0, 15) != 0);
            load = ($urandom_range(0, 5) == 0);
            if (load) begin
                pv = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255))
                                                  : int'($urandom_range(0, 12));
                period_in = W'(pv);
                center_in = 1'($urandom_range(0, 1));
                for (int i = 0; i < CH; i++) begin
                    tmp = int'($urandom_range(0, pv + 2));
                    if (tmp > 255) tmp = 255;
                    duty_in[i*W +: W] = W'(tmp);
                end
            end
            tick();
            chk("rnd_out", out, m_out);
            chk("rnd_ps", period_start, m_ps);
            chk("rnd_pending", pending, m_pend);
        end
        rst = 0; load = 0; enable = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
